// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the exception arbiter.
//   - CP0 cause codes, the common exception header values
//   - arbiter state encoding
//   - packed bundle of per-stage exception flags
//   - helpers: cause priority encoder and saturating counter step
package exception_ctrl_pkg;

   // Cause codes as CP0 records them; EXC_NOP marks "no exception"
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_NOP  = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } exc_state_e;

   // Ordered oldest pipeline stage first, matching the priority order
   typedef struct packed {
      logic if_adel;
      logic id_ri;
      logic id_sys;
      logic id_bp;
      logic ex_ov;
      logic mem_adel;
      logic mem_ades;
   } exc_flags_t;

   // Earliest-stage fault wins: it belongs to the oldest work on the instruction
   function automatic logic [4:0] exc_cause_sel(input exc_flags_t f);
      logic [4:0] c;
      if (f.if_adel) begin
         c = EXC_ADEL;
      end else if (f.id_ri) begin
         c = EXC_RI;
      end else if (f.id_sys) begin
         c = EXC_SYS;
      end else if (f.id_bp) begin
         c = EXC_BP;
      end else if (f.ex_ov) begin
         c = EXC_OV;
      end else if (f.mem_adel) begin
         c = EXC_ADEL;
      end else if (f.mem_ades) begin
         c = EXC_ADES;
      end else begin
         c = EXC_NOP;
      end
      return c;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hff) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// CP0-facing bundle of the exception arbiter.
//   i_timer_int        timer interrupt produced by CP0 (already synchronous)
//   i_status_exl       CP0 Status[1]
//   i_epc              CP0 EPC, ERET return address
//   o_except_cause     cause code, EXC_NOP when nothing is taken
//   o_int              pending interrupt vector, non-zero only when an interrupt is taken
//   o_current_pc       PC of the MEM-stage instruction
//   o_is_in_delay_slot delay-slot flag of the MEM-stage instruction
//   o_is_eret          ERET committed this cycle
// master: the arbiter; slave: CP0.
interface exception_ctrl_if;

   logic        i_timer_int;
   logic        i_status_exl;
   logic [31:0] i_epc;
   logic [4:0]  o_except_cause;
   logic [5:0]  o_int;
   logic [31:0] o_current_pc;
   logic        o_is_in_delay_slot;
   logic        o_is_eret;

   modport master (
      input  i_timer_int, i_status_exl, i_epc,
      output o_except_cause, o_int, o_current_pc, o_is_in_delay_slot, o_is_eret
   );

   modport slave (
      output i_timer_int, i_status_exl, i_epc,
      input  o_except_cause, o_int, o_current_pc, o_is_in_delay_slot, o_is_eret
   );

endinterface

// File: rtl/exception_ctrl_int_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk     destination clock
//   resetn  asynchronous active-low reset, clears both stages
//   d       asynchronous input bits
//   q       synchronised output, two clocks behind d
module exception_ctrl_int_sync #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // First stage may go metastable; second stage gives it a full cycle to settle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_r <= '0;
         sync_r <= '0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/exception_ctrl.sv
// Pipeline exception arbiter in front of CP0.
// Picks the single highest-priority event (interrupt, exception or ERET) at the
// MEM-stage commit point, presents it to CP0, flushes IF..MEM and then issues a
// one-cycle fetch redirect to the exception vector or to EPC.
//   clk, resetn              clock, asynchronous active-low reset
//   i_int_raw                asynchronous external interrupt lines
//   i_stall                  pipeline stall; blocks commit and freezes the flush count
//   i_mem_valid/pc/in_delay_slot  MEM-stage instruction
//   i_if_adel..i_mem_ades    exception flags travelling with the instruction
//   i_mem_eret               MEM-stage instruction is ERET
//   cp0                      CP0 bundle (status, EPC, timer in; cause, PC, int out)
//   o_flush                  kill IF..MEM
//   o_redirect_valid/pc      one-cycle fetch redirect
//   o_busy                   arbiter is flushing or redirecting
//   o_drop_cnt               saturating count of events masked by Status.EXL
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
   parameter int          FLUSH_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [5:0]              i_int_raw,
   input  logic                    i_stall,
   input  logic                    i_mem_valid,
   input  logic [31:0]             i_mem_pc,
   input  logic                    i_mem_in_delay_slot,
   input  logic                    i_if_adel,
   input  logic                    i_id_ri,
   input  logic                    i_id_sys,
   input  logic                    i_id_bp,
   input  logic                    i_ex_ov,
   input  logic                    i_mem_adel,
   input  logic                    i_mem_ades,
   input  logic                    i_mem_eret,
   exception_ctrl_if.master        cp0,
   output logic                    o_flush,
   output logic                    o_redirect_valid,
   output logic [31:0]             o_redirect_pc,
   output logic                    o_busy,
   output logic [7:0]              o_drop_cnt
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   logic [5:0]  int_sync_s;
   logic [5:0]  int_pend_s;
   exc_flags_t  flags_s;
   logic        any_int_s;
   logic        any_exc_s;
   logic        slot_ok_s;
   logic        exc_take_s;
   logic        eret_take_s;
   logic        drop_s;
   logic [4:0]  cause_s;
   logic [5:0]  int_out_s;

   exc_state_e  state_r;
   logic [3:0]  flush_cnt_r;
   logic [31:0] target_r;
   logic        redirect_valid_r;
   logic [31:0] redirect_pc_r;
   logic [7:0]  drop_cnt_r;
   logic        ready_r;

   exception_ctrl_int_sync #(
      .WIDTH (6)
   ) u_int_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (i_int_raw),
      .q      (int_sync_s)
   );

   // Event decode and commit qualification
   always_comb begin
      // The timer shares the top interrupt line with hardware interrupt 5
      int_pend_s = {int_sync_s[5] | cp0.i_timer_int, int_sync_s[4:0]};
      flags_s    = '{if_adel:  i_if_adel,  id_ri:    i_id_ri,
                     id_sys:   i_id_sys,   id_bp:    i_id_bp,
                     ex_ov:    i_ex_ov,    mem_adel: i_mem_adel,
                     mem_ades: i_mem_ades};
      any_int_s  = |int_pend_s;
      any_exc_s  = |flags_s;
      // ready_r keeps commit dead while reset is asserted and on the release edge
      slot_ok_s  = ready_r & i_mem_valid & ~i_stall & (state_r == ST_IDLE);
      exc_take_s = slot_ok_s & ~cp0.i_status_exl & (any_int_s | any_exc_s);
      // ERET normally runs with EXL set, so it is not gated by EXL
      eret_take_s = slot_ok_s & i_mem_eret & ~exc_take_s;
      drop_s      = slot_ok_s & cp0.i_status_exl & (any_int_s | any_exc_s);
   end

   // CP0 cause / interrupt selection for the commit cycle
   always_comb begin
      cause_s   = EXC_NOP;
      int_out_s = 6'b000000;
      if (exc_take_s) begin
         if (any_int_s) begin
            // CP0 fills in the interrupt cause from o_int itself
            int_out_s = int_pend_s;
         end else begin
            cause_s = exc_cause_sel(flags_s);
         end
      end else begin
         cause_s   = EXC_NOP;
         int_out_s = 6'b000000;
      end
   end

   assign cp0.o_except_cause     = cause_s;
   assign cp0.o_int              = int_out_s;
   assign cp0.o_is_eret          = eret_take_s;
   assign cp0.o_current_pc       = i_mem_pc;
   assign cp0.o_is_in_delay_slot = i_mem_in_delay_slot;

   // Flush starts in the commit cycle itself so the excepting instruction never retires
   assign o_flush          = (state_r == ST_FLUSH) | exc_take_s | eret_take_s;
   assign o_redirect_valid = redirect_valid_r;
   assign o_redirect_pc    = redirect_pc_r;
   assign o_busy           = (state_r != ST_IDLE);
   assign o_drop_cnt       = drop_cnt_r;

   // Commit enable: goes high one edge after reset release
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_r <= 1'b0;
      end else begin
         ready_r <= 1'b1;
      end
   end

   // Flush / redirect sequencer with registered redirect outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r          <= ST_IDLE;
         flush_cnt_r      <= 4'd0;
         target_r         <= 32'd0;
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               redirect_valid_r <= 1'b0;
               redirect_pc_r    <= 32'd0;
               if (exc_take_s) begin
                  state_r     <= ST_FLUSH;
                  flush_cnt_r <= FLUSH_LOAD;
                  target_r    <= EXC_VECTOR;
               end else if (eret_take_s) begin
                  state_r     <= ST_FLUSH;
                  flush_cnt_r <= FLUSH_LOAD;
                  target_r    <= cp0.i_epc;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               // A stalled cycle does not count toward the flush length
               if (i_stall) begin
                  state_r <= ST_FLUSH;
               end else if (flush_cnt_r == 4'd0) begin
                  state_r          <= ST_REDIRECT;
                  redirect_valid_r <= 1'b1;
                  redirect_pc_r    <= target_r;
               end else begin
                  flush_cnt_r <= flush_cnt_r - 4'd1;
               end
            end
            ST_REDIRECT: begin
               state_r          <= ST_IDLE;
               redirect_valid_r <= 1'b0;
               redirect_pc_r    <= 32'd0;
            end
            default: begin
               state_r          <= ST_IDLE;
               flush_cnt_r      <= 4'd0;
               redirect_valid_r <= 1'b0;
               redirect_pc_r    <= 32'd0;
            end
         endcase
      end
   end

   // Count events swallowed because CP0 is already handling one
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_cnt_r <= 8'd0;
      end else if (drop_s) begin
         drop_cnt_r <= sat_inc8(drop_cnt_r);
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl. Two instances (FLUSH_CYCLES 1 and 2)
// share one set of inputs; redirect expectations are queued at commit and
// popped by a monitor whenever a redirect pulse appears.
module tb_exception_ctrl;

   localparam logic [31:0] EXC_VEC = 32'h00400004;

   typedef struct {
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic [5:0]  int_raw;
   logic        timer_int, status_exl, stall, mem_valid, mem_ds, mem_eret;
   logic        if_adel, id_ri, id_sys, id_bp, ex_ov, mem_adel, mem_ades;
   logic [31:0] mem_pc, epc;

   logic [4:0]  cause_s [2];
   logic [5:0]  int_s   [2];
   logic [31:0] cpc_s   [2];
   logic        ds_s    [2];
   logic        eret_s  [2];
   logic        flush_s [2];
   logic        rv_s    [2];
   logic [31:0] rpc_s   [2];
   logic        busy_s  [2];
   logic [7:0]  drop_s  [2];

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   // Cycle index used to time-stamp commits and redirects
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      exception_ctrl_if cp0_if ();
      assign cp0_if.i_timer_int  = timer_int;
      assign cp0_if.i_status_exl = status_exl;
      assign cp0_if.i_epc        = epc;

      exception_ctrl #(
         .EXC_VECTOR   (EXC_VEC),
         .FLUSH_CYCLES (g + 1)
      ) u_dut (
         .clk                 (clk),
         .resetn              (resetn),
         .i_int_raw           (int_raw),
         .i_stall             (stall),
         .i_mem_valid         (mem_valid),
         .i_mem_pc            (mem_pc),
         .i_mem_in_delay_slot (mem_ds),
         .i_if_adel           (if_adel),
         .i_id_ri             (id_ri),
         .i_id_sys            (id_sys),
         .i_id_bp             (id_bp),
         .i_ex_ov             (ex_ov),
         .i_mem_adel          (mem_adel),
         .i_mem_ades          (mem_ades),
         .i_mem_eret          (mem_eret),
         .cp0                 (cp0_if.master),
         .o_flush             (flush_s[g]),
         .o_redirect_valid    (rv_s[g]),
         .o_redirect_pc       (rpc_s[g]),
         .o_busy              (busy_s[g]),
         .o_drop_cnt          (drop_s[g])
      );

      assign cause_s[g] = cp0_if.o_except_cause;
      assign int_s[g]   = cp0_if.o_int;
      assign cpc_s[g]   = cp0_if.o_current_pc;
      assign ds_s[g]    = cp0_if.o_is_in_delay_slot;
      assign eret_s[g]  = cp0_if.o_is_eret;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: every redirect pulse must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rv_s[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               check_eq($sformatf("dut%0d unexpected redirect", d), 32'(rv_s[d]), 32'd0);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               check_eq($sformatf("dut%0d redirect_pc", d), rpc_s[d], e.pc);
               check_eq($sformatf("dut%0d redirect_cycle", d), 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   task automatic clear_events();
      mem_valid = 1'b0; mem_ds = 1'b0; mem_eret = 1'b0; status_exl = 1'b0;
      if_adel = 1'b0; id_ri = 1'b0; id_sys = 1'b0; id_bp = 1'b0;
      ex_ov = 1'b0; mem_adel = 1'b0; mem_ades = 1'b0; timer_int = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy_s[0] || busy_s[1] || q0.size() != 0 || q1.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, " redirects outstanding"}, 32'(q0.size() + q1.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Inputs are already driven; check the commit cycle, queue the redirect, finish the sequence
   task automatic take_event(input string tag, input logic [4:0] e_cause, input logic [5:0] e_int,
                             input logic e_eret, input logic [31:0] e_pc, input logic e_ds,
                             input logic [31:0] e_rpc, input int stall_n, input logic hold);
      int t;
      @(negedge clk);
      t = cyc;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("%s dut%0d cause", tag, d), 32'(cause_s[d]), 32'(e_cause));
         check_eq($sformatf("%s dut%0d int", tag, d), 32'(int_s[d]), 32'(e_int));
         check_eq($sformatf("%s dut%0d is_eret", tag, d), 32'(eret_s[d]), 32'(e_eret));
         check_eq($sformatf("%s dut%0d flush", tag, d), 32'(flush_s[d]), 32'd1);
         check_eq($sformatf("%s dut%0d current_pc", tag, d), cpc_s[d], e_pc);
         check_eq($sformatf("%s dut%0d delay_slot", tag, d), 32'(ds_s[d]), 32'(e_ds));
      end
      q0.push_back('{e_rpc, t + 2 + stall_n});
      q1.push_back('{e_rpc, t + 3 + stall_n});
      @(posedge clk); #1;
      if (hold) begin
         // Same event still presented while flushing must be ignored
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s dut%0d busy cause", tag, d), 32'(cause_s[d]), 32'd31);
            check_eq($sformatf("%s dut%0d busy flush", tag, d), 32'(flush_s[d]), 32'd1);
         end
         @(posedge clk); #1;
      end
      clear_events();
      if (stall_n > 0) begin
         stall = 1'b1;
         repeat (stall_n) @(posedge clk);
         #1;
         stall = 1'b0;
      end
      wait_idle(tag);
   endtask

   initial begin
      int flush_seen;
      resetn = 1'b0; int_raw = 6'd0; stall = 1'b0; mem_pc = 32'd0; epc = 32'd0;
      clear_events();
      // An excepting instruction during reset must not surface
      mem_valid = 1'b1; id_ri = 1'b1; mem_pc = 32'h00400010;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("reset dut%0d cause", d), 32'(cause_s[d]), 32'd31);
         check_eq($sformatf("reset dut%0d int", d), 32'(int_s[d]), 32'd0);
         check_eq($sformatf("reset dut%0d is_eret", d), 32'(eret_s[d]), 32'd0);
         check_eq($sformatf("reset dut%0d flush", d), 32'(flush_s[d]), 32'd0);
         check_eq($sformatf("reset dut%0d redirect_valid", d), 32'(rv_s[d]), 32'd0);
         check_eq($sformatf("reset dut%0d redirect_pc", d), rpc_s[d], 32'd0);
         check_eq($sformatf("reset dut%0d busy", d), 32'(busy_s[d]), 32'd0);
         check_eq($sformatf("reset dut%0d drop_cnt", d), 32'(drop_s[d]), 32'd0);
      end
      @(posedge clk); #1;
      clear_events();
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reserved instruction, plain exception
      mem_valid = 1'b1; id_ri = 1'b1; mem_pc = 32'h00400020;
      take_event("ri", 5'd10, 6'd0, 1'b0, 32'h00400020, 1'b0, EXC_VEC, 0, 1'b0);

      // Address error on store in a delay slot, held while busy
      mem_valid = 1'b1; mem_ades = 1'b1; mem_ds = 1'b1; mem_pc = 32'h00400104;
      take_event("ades", 5'd5, 6'd0, 1'b0, 32'h00400104, 1'b1, EXC_VEC, 0, 1'b1);

      // Priority between simultaneous exception flags
      mem_valid = 1'b1; if_adel = 1'b1; mem_ades = 1'b1; mem_pc = 32'h00400200;
      take_event("if_adel>ades", 5'd4, 6'd0, 1'b0, 32'h00400200, 1'b0, EXC_VEC, 0, 1'b0);
      mem_valid = 1'b1; id_ri = 1'b1; id_sys = 1'b1; mem_pc = 32'h00400204;
      take_event("ri>sys", 5'd10, 6'd0, 1'b0, 32'h00400204, 1'b0, EXC_VEC, 0, 1'b0);
      mem_valid = 1'b1; id_sys = 1'b1; id_bp = 1'b1; mem_pc = 32'h00400208;
      take_event("sys>bp", 5'd8, 6'd0, 1'b0, 32'h00400208, 1'b0, EXC_VEC, 0, 1'b0);
      mem_valid = 1'b1; mem_adel = 1'b1; mem_ades = 1'b1; mem_pc = 32'h0040020c;
      take_event("mem_adel>ades", 5'd4, 6'd0, 1'b0, 32'h0040020c, 1'b0, EXC_VEC, 0, 1'b0);

      // Interrupt arrives with an overflow; synchroniser delay lets OV through first
      int_raw = 6'b000100;
      mem_valid = 1'b1; ex_ov = 1'b1; mem_pc = 32'h00400300;
      take_event("ov before int", 5'd12, 6'd0, 1'b0, 32'h00400300, 1'b0, EXC_VEC, 0, 1'b0);
      // Re-executed instruction: interrupt now visible and wins over OV
      mem_valid = 1'b1; ex_ov = 1'b1; mem_pc = 32'h00400300;
      take_event("int over ov", 5'd31, 6'b000100, 1'b0, 32'h00400300, 1'b0, EXC_VEC, 0, 1'b0);
      int_raw = 6'd0;
      repeat (3) @(posedge clk);
      #1;

      // Timer folds into the top interrupt bit
      mem_valid = 1'b1; timer_int = 1'b1; mem_pc = 32'h00400310;
      take_event("timer", 5'd31, 6'b100000, 1'b0, 32'h00400310, 1'b0, EXC_VEC, 0, 1'b0);

      // ERET returns to EPC (runs with EXL set)
      mem_valid = 1'b1; mem_eret = 1'b1; status_exl = 1'b1; epc = 32'h00400040; mem_pc = 32'h00400400;
      take_event("eret", 5'd31, 6'd0, 1'b1, 32'h00400400, 1'b0, 32'h00400040, 0, 1'b0);

      // Exception beats ERET
      mem_valid = 1'b1; mem_eret = 1'b1; id_bp = 1'b1; epc = 32'h00400080; mem_pc = 32'h00400404;
      take_event("bp>eret", 5'd9, 6'd0, 1'b0, 32'h00400404, 1'b0, EXC_VEC, 0, 1'b0);

      // Three stall cycles during flush push the redirect out by three
      mem_valid = 1'b1; id_ri = 1'b1; mem_pc = 32'h00400500;
      take_event("stall", 5'd10, 6'd0, 1'b0, 32'h00400500, 1'b0, EXC_VEC, 3, 1'b0);

      // EXL masks SYS: no flush, no redirect, drop counter saturates
      flush_seen = 0;
      mem_valid = 1'b1; id_sys = 1'b1; status_exl = 1'b1; mem_pc = 32'h00400600;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (flush_s[0] || flush_s[1]) flush_seen++;
         if (i == 1 || i == 254 || i == 255) begin
            check_eq($sformatf("drop dut0 cnt@%0d", i), 32'(drop_s[0]), 32'(i));
            check_eq($sformatf("drop dut1 cnt@%0d", i), 32'(drop_s[1]), 32'(i));
         end
         @(posedge clk); #1;
      end
      clear_events();
      @(negedge clk);
      check_eq("drop flush seen", 32'(flush_seen), 32'd0);
      check_eq("drop dut0 saturated", 32'(drop_s[0]), 32'd255);
      check_eq("drop dut1 saturated", 32'(drop_s[1]), 32'd255);
      @(posedge clk); #1;

      // Reset in the middle of a flush: back to IDLE at once, no redirect afterwards
      mem_valid = 1'b1; id_ri = 1'b1; mem_pc = 32'h00400700;
      @(negedge clk);
      check_eq("rst-mid dut1 commit flush", 32'(flush_s[1]), 32'd1);
      @(posedge clk); #1;
      clear_events();
      @(negedge clk);
      check_eq("rst-mid dut0 busy before", 32'(busy_s[0]), 32'd1);
      check_eq("rst-mid dut1 busy before", 32'(busy_s[1]), 32'd1);
      #1 resetn = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("rst-mid dut%0d flush", d), 32'(flush_s[d]), 32'd0);
         check_eq($sformatf("rst-mid dut%0d busy", d), 32'(busy_s[d]), 32'd0);
         check_eq($sformatf("rst-mid dut%0d drop_cnt", d), 32'(drop_s[d]), 32'd0);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      check_eq("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Pipeline exception arbiter that sits directly upstream of the CP0 block. It does four things:
- collects per-stage exception flags, the ERET indication and external/timer interrupts;
- picks the single highest-priority event at the MEM-stage commit point;
- drives CP0's cause, PC, delay-slot and interrupt inputs;
- sequences the pipeline flush and the fetch redirect (exception vector or EPC).

## Interface
Parameters:
- EXC_VECTOR, 32'h00400004, redirect target for every exception and interrupt
- FLUSH_CYCLES, 1, cycles o_flush stays high after commit; legal range 1..15

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- i_int_raw  in  6  asynchronous external interrupt lines
- i_timer_int  in  1  timer interrupt from CP0, already synchronous
- i_stall  in  1  pipeline stall; while high, nothing commits
- i_mem_valid  in  1  MEM stage holds a real instruction
- i_mem_pc  in  32  PC of the MEM-stage instruction
- i_mem_in_delay_slot  in  1  MEM-stage instruction is in a delay slot
- i_if_adel, i_id_ri, i_id_sys, i_id_bp, i_ex_ov, i_mem_adel, i_mem_ades  in  1 each  exception flags carried down to MEM with the instruction
- i_mem_eret  in  1  MEM-stage instruction is ERET
- i_status_exl  in  1  CP0 Status[1]
- i_epc  in  32  CP0 EPC
- o_except_cause  out  5  to CP0; EXC_CAUSE_NOP when idle
- o_int  out  6  to CP0
- o_current_pc  out  32  to CP0
- o_is_in_delay_slot  out  1  to CP0
- o_is_eret  out  1  to CP0
- o_flush  out  1  kill all IF..MEM stages
- o_redirect_valid  out  1  one-cycle fetch redirect strobe
- o_redirect_pc  out  32  redirect target
- o_busy  out  1  state is not IDLE
- o_drop_cnt  out  8  saturating count of events masked by EXL

## Operation
- Interrupt synchronisation:
  - i_int_raw passes through a 2-FF synchroniser to give int_sync.
  - Pending vector is int_pend = {int_sync[5] | i_timer_int, int_sync[4:0]}.
- Commit condition: `commit = i_mem_valid & ~i_stall & state==IDLE & ~i_status_exl`.
- Priority at commit, highest first, with cause codes:
  - interrupt (any int_pend bit): 0
  - if_adel: 4
  - id_ri: 10
  - id_sys: 8
  - id_bp: 9
  - ex_ov: 12
  - mem_adel: 4
  - mem_ades: 5
  - eret: handled as ERET, not an exception
- Interrupt taken:
  - o_int = int_pend and o_except_cause = NOP.
  - CP0 records cause INT itself.
- Exception taken: o_except_cause = code and o_int = 0.
- Exception or interrupt (either case above) also drives:
  - o_current_pc = i_mem_pc;
  - o_is_in_delay_slot = i_mem_in_delay_slot;
  - o_flush = 1 in the same cycle (combinational);
  - target register ← EXC_VECTOR.
- ERET (no exception or interrupt present):
  - o_is_eret = 1 and o_flush = 1.
  - Target register ← i_epc, sampled in the commit cycle.
- Outside a commit cycle: o_except_cause = NOP (5'b11111), o_int = 0, o_is_eret = 0, and o_current_pc / o_is_in_delay_slot follow the MEM inputs.
- EXL masking:
  - If i_status_exl = 1 and i_mem_valid & ~i_stall & IDLE while any event is present, the event is suppressed, the instruction retires normally, and o_drop_cnt increments (saturates at 255).
  - ERET is never masked.
- State machine:
  - IDLE → FLUSH on a commit carrying an event; counter loads FLUSH_CYCLES-1.
  - FLUSH: o_flush = 1; counter decrements when ~i_stall; at 0 with ~i_stall → REDIRECT.
  - REDIRECT: o_redirect_valid = 1 and o_redirect_pc = target for exactly one cycle → IDLE.
- o_busy = (state != IDLE).

## Timing
- Reset values: state IDLE, synchroniser 0, target 0, counter 0, o_drop_cnt 0, o_flush 0, o_redirect_valid 0, o_redirect_pc 0, o_int 0, o_is_eret 0, o_except_cause NOP.
- External interrupt latency: 2 clocks from i_int_raw to int_pend.
- Redirect latency: commit at cycle T → o_redirect_valid at T+FLUSH_CYCLES+1 when no stall; each stalled FLUSH cycle adds 1.
- Simultaneous interrupt and exception: the interrupt wins; the excepting instruction re-executes after return.
- Simultaneous exception and ERET: the exception wins; o_is_eret = 0.
- Events arriving while busy are ignored, since the pipeline is being flushed.
- Reset asserted mid-sequence returns immediately to IDLE; no redirect is issued.

## Structure
- Cause codes (INT, ADEL, ADES, SYS, BP, RI, OV, NOP) come from the shared Exception.v header; no local literals.
- One sub-module, `int_sync`: a parameterised-width 2-FF synchroniser with async active-low reset.

## Test plan
- RI at PC 0x00400020, not in delay slot, EXL=0, FLUSH_CYCLES=1:
  - T: cause=10, flush=1, current_pc=0x00400020.
  - T+2: redirect_valid=1, redirect_pc=0x00400004.
- ADES with i_mem_in_delay_slot=1 and PC 0x00400104 → cause=5, o_is_in_delay_slot=1, one redirect pulse.
- i_int_raw[2] rises while a valid instruction sits in MEM together with ex_ov:
  - interrupt is not seen for 2 cycles, so the first commit takes OV (cause 12);
  - after return, o_int=6'b000100 and cause=NOP.
- ERET with i_epc=0x00400040 → o_is_eret=1 at commit; redirect_pc=0x00400040; cause stays NOP.
- SYS with EXL=1 repeated 300 times → no flush, no redirect; o_drop_cnt saturates at 255.
- Stall held 3 cycles during FLUSH with FLUSH_CYCLES=2:
  - redirect is delayed by 3 cycles;
  - resetn pulled low in FLUSH → o_flush=0 and state IDLE immediately, with no redirect pulse.
